pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The module SHALL have one parameter: RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 The module SHALL have the following ports, in this order, one per line (name, direction, width, meaning):
- CLK          input   1   rising-edge clock, sole clock domain
- RST_N        input   1   asynchronous active-low reset
- PC_NEXT      input   32  redirect target from the upstream next-PC 4:1 select; sampled only when REDIRECT=1
- REDIRECT     input   1   branch/jump/trap taken this cycle
- PC           output  32  current fetch PC
- PC_PLUS4     output  32  PC+4, wrap modulo 2^32; drives the select's sequential input
- IMEM_REQ     output  1   one-cycle fetch request; memory always accepts
- IMEM_ADDR    output  32  fetch address, equal to PC when IMEM_REQ=1
- IMEM_RVALID  input   1   read data valid, 1..N cycles after IMEM_REQ
- IMEM_RDATA   input   32  instruction word
- IR_VALID     output  1   IR/IR_PC hold a valid entry
- IR_READY     input   1   decode accepts the entry
- IR           output  32  head instruction word
- IR_PC        output  32  PC of head instruction
- MISALIGN     output  1   sticky misaligned-redirect flag
REQ-003 Clock and reset polarity SHALL be exactly as decided: one clock, CLK; reset RST_N, asynchronous, active-low.

Function
REQ-004 Instruction buffer SHALL be a 2-entry FIFO of {word, pc}; IR_VALID = (count != 0); IR/IR_PC show the head entry combinationally.
REQ-005 Pop SHALL occur when IR_VALID & IR_READY; push SHALL occur on an accepted IMEM_RVALID; pop and push in the same cycle SHALL leave count unchanged.
REQ-006 The FSM SHALL have states BOOT, IDLE, WAIT, DRAIN and HALT; reset state SHALL be BOOT.
REQ-007 BOOT SHALL last exactly one cycle after reset release and SHALL then go to IDLE with no request issued.
REQ-008 In IDLE, IMEM_REQ SHALL equal (count_after_pop < 2) & !REDIRECT; on issue, the FSM SHALL enter WAIT and PC SHALL update to PC_PLUS4.
REQ-009 The request-issue rule SHALL allow at most one outstanding request, so a response always finds buffer space.
REQ-010 In WAIT, IMEM_RVALID SHALL push {IMEM_RDATA, issuing PC} and the FSM SHALL return to IDLE; the next request SHALL issue no earlier than the following cycle.
REQ-011 A response arriving with IMEM_RVALID while in IDLE or BOOT SHALL be ignored.
REQ-012 REDIRECT=1 in any state except HALT SHALL, at that edge, load PC from PC_NEXT and empty the FIFO; IMEM_REQ SHALL be 0 that cycle.
REQ-013 REDIRECT in WAIT, or REDIRECT coincident with IMEM_RVALID, SHALL discard that response (not pushed).
REQ-014 After REDIRECT in WAIT, the FSM SHALL go to DRAIN; DRAIN SHALL discard the next IMEM_RVALID and go to IDLE.
REQ-015 A further REDIRECT while in DRAIN SHALL reload PC and keep the FSM in DRAIN.
REQ-016 A REDIRECT in IDLE or BOOT SHALL go to IDLE.
REQ-017 A pop coincident with REDIRECT SHALL be ignored; the FIFO flushes.
REQ-018 PC and PC_PLUS4 arithmetic SHALL be 32-bit unsigned, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-019 While RST_N=0, all state SHALL be forced to reset values: PC=RESET_VECTOR, state=BOOT, count=0, IR_VALID=0, IMEM_REQ=0, MISALIGN=0; IR and IR_PC SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL abandon any outstanding request; a late IMEM_RVALID after release SHALL be ignored per REQ-011.

Configuration
REQ-021 With macro PC_MISALIGN_CHK_EN defined, a REDIRECT with PC_NEXT[1:0]!=2'b00 SHALL set MISALIGN=1 and enter HALT.
REQ-022 HALT SHALL issue no requests, SHALL ignore REDIRECT and IMEM_RVALID, and SHALL still drain the FIFO to decode; only reset exits HALT.
REQ-023 Without PC_MISALIGN_CHK_EN, PC_NEXT[1:0] SHALL be treated as 2'b00 and MISALIGN SHALL be tied to 0; the port SHALL exist in both builds.

Verification
REQ-024 Reset release, RESET_VECTOR=32'h100, 1-cycle memory, IR_READY=1 -> first IMEM_REQ 2nd cycle after release at 32'h100; IR_PC sequence 100,104,108.
REQ-025 IR_READY=0, memory latency 1 -> exactly two words buffered (count=2), then IMEM_REQ stays 0 until a pop.
REQ-026 REDIRECT to 32'h200 while in WAIT, with 3-cycle latency -> stale word dropped, next IMEM_ADDR=32'h200, and no entry with IR_PC=32'h104 reaches decode.
REQ-027 REDIRECT, IMEM_RVALID and pop in the same cycle -> FIFO empty next cycle, PC=PC_NEXT.
REQ-028 PC=32'hFFFF_FFFC fetch -> next IMEM_ADDR=32'h0000_0000.
REQ-029 With PC_MISALIGN_CHK_EN, REDIRECT to 32'h202 -> MISALIGN=1, no further IMEM_REQ until RST_N low; without the macro, the next fetch is at 32'h200.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch front end: PC register, single-outstanding IMEM request FSM and a 2-entry {word, pc} buffer to decode.
// Optional PC_MISALIGN_CHK_EN: misaligned redirect targets set MISALIGN and park the FSM in HALT.
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC_NEXT,
  input  logic        REDIRECT,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        MISALIGN
);

  typedef enum logic [2:0] {BOOT, IDLE, WAIT, DRAIN, HALT} state_e;
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d, req_pc_q, req_pc_d;
  ent_t [1:0]      buf_q, buf_d;
  logic [1:0]      cnt_q, cnt_d, cnt_ap;
  logic            mis_q, mis_d;
  logic            redir, pop, push, req, bad_tgt;
  logic [31:0]     tgt;

`ifdef PC_MISALIGN_CHK_EN
  assign bad_tgt = (PC_NEXT[1:0] != 2'b00);
  assign tgt     = PC_NEXT;
`else
  assign bad_tgt = 1'b0;
  assign tgt     = PC_NEXT & ~32'h3;
`endif

  assign redir  = REDIRECT && (state_q != HALT);
  assign pop    = (cnt_q != 2'd0) && IR_READY && !redir;
  assign cnt_ap = cnt_q - {1'b0, pop};
  // Only issuing from IDLE keeps one request in flight, so a push always finds room.
  assign req    = (state_q == IDLE) && (cnt_ap < 2'd2) && !REDIRECT;
  assign push   = (state_q == WAIT) && IMEM_RVALID && !redir;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    mis_d    = mis_q;

    if (redir) begin
      cnt_d = 2'd0;
      pc_d  = tgt;
    end else begin
      if (pop) buf_d[0] = buf_q[1];
      if (push) buf_d[cnt_ap[0]] = '{word: IMEM_RDATA, pc: req_pc_q};
      cnt_d = cnt_ap + {1'b0, push};
      if (req) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
      end
    end

    // A redirect that coincides with the response has already consumed it,
    // so DRAIN is only entered while the response is still in flight.
    case (state_q)
      BOOT:    state_d = IDLE;
      IDLE:    if (!redir && req) state_d = WAIT;
      WAIT:    if (redir) state_d = IMEM_RVALID ? IDLE : DRAIN;
               else if (IMEM_RVALID) state_d = IDLE;
      DRAIN:   if (IMEM_RVALID) state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    if (redir && bad_tgt) begin
      state_d = HALT;
      mis_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= RESET_VECTOR;
      buf_q    <= '0;
      cnt_q    <= 2'd0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
    end
  end

  assign PC        = pc_q;
  assign PC_PLUS4  = pc_q + 32'd4;
  assign IMEM_REQ  = req;
  assign IMEM_ADDR = pc_q;
  assign IR_VALID  = (cnt_q != 2'd0);
  assign IR        = buf_q[0].word;
  assign IR_PC     = buf_q[0].pc;
  assign MISALIGN  = mis_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed phases push expected {word, pc}; a monitor checks every accepted entry.
module tb_pc_fetch;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] PC_NEXT = '0;
  logic        REDIRECT = 1'b0;
  logic [31:0] PC, PC_PLUS4, IMEM_ADDR, IR, IR_PC;
  logic        IMEM_REQ, IR_VALID, MISALIGN;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        IR_READY = 1'b0;

  always #5 CLK = ~CLK;

  pc_fetch #(.RESET_VECTOR(32'h100)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC_NEXT(PC_NEXT), .REDIRECT(REDIRECT),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .IR_VALID(IR_VALID),
    .IR_READY(IR_READY), .IR(IR), .IR_PC(IR_PC), .MISALIGN(MISALIGN)
  );

  int          n_cmp = 0, n_bad = 0, n_req = 0, mem_lat = 1, pend = 0;
  logic        req_seen = 1'b0, arm104 = 1'b0, saw104 = 1'b0;
  logic [31:0] req_a, pend_a, a;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] ad);
    return ad ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] ad);
    exp_q.push_back({word_of(ad), ad});
  endtask

  // Sample at negedge: record requests for the memory model and check accepted entries.
  always @(negedge CLK) begin
    logic [63:0] e;
    if (IMEM_REQ) begin
      req_seen = 1'b1;
      req_a    = IMEM_ADDR;
      n_req++;
    end
    if (RST_N && IR_VALID && IR_READY && !REDIRECT) begin
      if (arm104 && IR_PC == 32'h104) saw104 = 1'b1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ir_pc", IR_PC, e[31:0]);
        chk("ir_word", IR, e[63:32]);
      end
    end
  end

  // Fixed-latency memory: responds mem_lat cycles after the request cycle.
  always @(posedge CLK) begin
    #1;
    IMEM_RVALID = 1'b0;
    if (!RST_N) begin
      pend = 0;
      req_seen = 1'b0;
    end else begin
      if (req_seen) begin
        pend = mem_lat;
        pend_a = req_a;
        req_seen = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          IMEM_RVALID = 1'b1;
          IMEM_RDATA  = word_of(pend_a);
        end
      end
    end
  end

  task automatic wait_req(output logic [31:0] ad);
    int k;
    k = 0;
    @(negedge CLK);
    while (!IMEM_REQ && k < 50) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (!IMEM_REQ) begin
      n_bad++;
      $display("FAIL wait_req: IMEM_REQ got 0 expected 1 within 50 cycles");
    end
    ad = IMEM_ADDR;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    REDIRECT = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] tg);
    @(posedge CLK); #1;
    REDIRECT = 1'b1;
    PC_NEXT  = tg;
    exp_q.delete();
    @(posedge CLK); #1;
    REDIRECT = 1'b0;
  endtask

  task automatic drained(input string nm);
    chk(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state, boot cycle and first sequential fetches.
    IR_READY = 1'b1;
    mem_lat  = 1;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    repeat (2) @(negedge CLK);
    chk("rst_pc", PC, 32'h100);
    chk("rst_pc_plus4", PC_PLUS4, 32'h104);
    chk("rst_ir_valid", IR_VALID, 0);
    chk("rst_imem_req", IMEM_REQ, 0);
    chk("rst_misalign", MISALIGN, 0);
    chk("rst_ir", IR, 0);
    chk("rst_ir_pc", IR_PC, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("boot_no_req", IMEM_REQ, 0);
    @(negedge CLK);
    chk("first_req", IMEM_REQ, 1);
    chk("first_addr", IMEM_ADDR, 32'h100);
    repeat (12) @(negedge CLK);
    drained("t1_drained");

    // Decode stalled: exactly two words buffered, then no requests until a pop.
    IR_READY = 1'b0;
    do_reset();
    n_req = 0;
    repeat (12) @(negedge CLK);
    chk("full_req_count", n_req, 2);
    chk("full_ir_valid", IR_VALID, 1);
    chk("full_head_pc", IR_PC, 32'h100);
    chk("full_no_req", IMEM_REQ, 0);
    push_exp(32'h100);
    @(posedge CLK); #1;
    IR_READY = 1'b1;
    @(negedge CLK);
    chk("pop_frees_req", IMEM_REQ, 1);
    chk("pop_req_addr", IMEM_ADDR, 32'h108);
    @(posedge CLK); #1;
    IR_READY = 1'b0;
    repeat (3) @(negedge CLK);
    drained("t2_drained");
    chk("t2_head_after_pop", IR_PC, 32'h104);

    // Redirect while WAIT with 3-cycle memory: stale 104 never reaches decode.
    IR_READY = 1'b1;
    mem_lat  = 3;
    do_reset();
    push_exp(32'h100);
    arm104 = 1'b1;
    wait_req(a); chk("t3_req0", a, 32'h100);
    wait_req(a); chk("t3_req1", a, 32'h104);
    do_redirect(32'h200);
    push_exp(32'h200); push_exp(32'h204);
    wait_req(a); chk("t3_req_after_redirect", a, 32'h200);
    repeat (12) @(negedge CLK);
    drained("t3_drained");
    chk("t3_no_104", saw104, 0);
    arm104 = 1'b0;

    // Redirect, response and pop in the same cycle.
    IR_READY = 1'b0;
    mem_lat  = 1;
    do_reset();
    wait_req(a); chk("t4_req0", a, 32'h100);
    wait_req(a); chk("t4_req1", a, 32'h104);
    @(posedge CLK); #1;
    REDIRECT = 1'b1;
    PC_NEXT  = 32'h300;
    IR_READY = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk("t4_valid_at_redirect", IR_VALID, 1);
    chk("t4_no_req_at_redirect", IMEM_REQ, 0);
    @(posedge CLK); #1;
    REDIRECT = 1'b0;
    IR_READY = 1'b0;
    push_exp(32'h300);
    @(negedge CLK);
    chk("t4_flushed", IR_VALID, 0);
    chk("t4_pc", PC, 32'h300);
    chk("t4_req_resumes", IMEM_REQ, 1);
    @(posedge CLK); #1;
    IR_READY = 1'b1;
    repeat (6) @(negedge CLK);
    drained("t4_drained");

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    wait_req(a); chk("wrap_req0", a, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0);
    wait_req(a); chk("wrap_req1", a, 32'h0);
    repeat (6) @(negedge CLK);
    drained("t5_drained");

    // Misaligned redirect target.
    do_redirect(32'h202);
`ifdef PC_MISALIGN_CHK_EN
    n_req = 0;
    repeat (10) @(negedge CLK);
    chk("halt_misalign", MISALIGN, 1);
    chk("halt_no_req", n_req, 0);
    do_reset();
    @(negedge CLK);
    chk("halt_reset_clears", MISALIGN, 0);
`else
    push_exp(32'h200);
    wait_req(a); chk("misalign_masked_addr", a, 32'h200);
    chk("misalign_tied_0", MISALIGN, 0);
    repeat (6) @(negedge CLK);
    drained("t6_drained");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
